// File: rtl/ctrl_pipe_chain.sv
// Parametrised execute..write-back control-word pipeline with per-stage stall/flush,
// bubble insertion and a multicycle-op hold FSM. Optional perf counters: CTRL_PIPE_PERF_EN.

module ctrl_pipe_stage #(
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              hold_i,
    input  logic              bubble_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              valid_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              valid_o
);
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              valid_q, valid_d;

    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        if (flush_i || (!hold_i && bubble_i)) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
        end else if (!hold_i) begin
            ctrl_d  = ctrl_i;
            valid_d = valid_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    assign ctrl_o  = ctrl_q;
    assign valid_o = valid_q;
endmodule

module ctrl_pipe_chain #(
    parameter int CTRL_W    = 16,
    parameter int NSTAGE    = 3,
    parameter int MC_CYCLES = 36
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CTRL_W-1:0]        ctrl_d,
    input  logic                     valid_d,
    input  logic                     mc_d,
    input  logic [NSTAGE-1:0]        stall,
    input  logic [NSTAGE-1:0]        flush,
    output logic [NSTAGE*CTRL_W-1:0] ctrl_q,
    output logic [NSTAGE-1:0]        valid_q,
    output logic                     stall_req,
    output logic                     mc_busy,
    output logic                     mc_done,
    output logic [31:0]              perf_retired,
    output logic [31:0]              perf_stall
);
    localparam int CNT_W = $clog2(MC_CYCLES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_CYCLES - 2);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [NSTAGE-1:0][CTRL_W-1:0] stg_ctrl;
    logic [NSTAGE-1:0]             stg_vld;
    logic [NSTAGE-1:0]             hold;
    logic                          mc_hold;

    logic [1:0]       st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mc_flag_q, mc_flag_d;

    // Hold propagates from the oldest stage toward stage 0; flush never feeds it.
    always_comb begin
        logic acc;
        acc = 1'b0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            acc     = acc | stall[i];
            hold[i] = acc;
        end
        hold[0] = hold[0] | mc_hold;
    end

    assign stall_req = hold[0];

    for (genvar g = 0; g < NSTAGE; g++) begin : g_stg
        if (g == 0) begin : g_head
            ctrl_pipe_stage #(.CTRL_W(CTRL_W)) u_stg (
                .clk     (clk),
                .rst     (rst),
                .flush_i (flush[0]),
                .hold_i  (hold[0]),
                .bubble_i(1'b0),
                .ctrl_i  (ctrl_d),
                .valid_i (valid_d),
                .ctrl_o  (stg_ctrl[0]),
                .valid_o (stg_vld[0])
            );
        end else begin : g_tail
            ctrl_pipe_stage #(.CTRL_W(CTRL_W)) u_stg (
                .clk     (clk),
                .rst     (rst),
                .flush_i (flush[g]),
                .hold_i  (hold[g]),
                .bubble_i(hold[g-1]),
                .ctrl_i  (stg_ctrl[g-1]),
                .valid_i (stg_vld[g-1]),
                .ctrl_o  (stg_ctrl[g]),
                .valid_o (stg_vld[g])
            );
        end
    end

    assign ctrl_q  = stg_ctrl;
    assign valid_q = stg_vld;

    logic s0_load, mc_enter;
    assign s0_load  = !flush[0] && !hold[0];
    assign mc_enter = s0_load && valid_d && mc_d;

    always_comb begin
        mc_flag_d = mc_flag_q;
        if (flush[0])
            mc_flag_d = 1'b0;
        else if (!hold[0])
            mc_flag_d = valid_d & mc_d;
    end

    // BUSY starts on the edge the op lands in stage 0, so BUSY (MC_CYCLES-1) + DONE (1)
    // gives MC_CYCLES cycles of stage-0 occupancy.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        case (st_q)
            ST_IDLE: begin
                if (mc_enter) begin
                    st_d  = ST_BUSY;
                    cnt_d = CNT_INIT;
                end
            end
            ST_BUSY: begin
                if (flush[0]) begin
                    st_d  = ST_IDLE;
                    cnt_d = '0;
                end else if (cnt_q == '0) begin
                    st_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (flush[0]) begin
                    st_d  = ST_IDLE;
                    cnt_d = '0;
                end else if (!hold[0]) begin
                    // A back-to-back mc op may enter as the finished one leaves.
                    if (mc_enter) begin
                        st_d  = ST_BUSY;
                        cnt_d = CNT_INIT;
                    end else begin
                        st_d = ST_IDLE;
                    end
                end
            end
            default: begin
                st_d  = ST_IDLE;
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q      <= ST_IDLE;
            cnt_q     <= '0;
            mc_flag_q <= 1'b0;
        end else begin
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            mc_flag_q <= mc_flag_d;
        end
    end

    assign mc_hold = (st_q == ST_BUSY) && mc_flag_q;
    assign mc_busy = (st_q != ST_IDLE);
    assign mc_done = (st_q == ST_DONE);

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] perf_ret_q, perf_stl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ret_q <= '0;
            perf_stl_q <= '0;
        end else begin
            if (stg_vld[NSTAGE-1] && !hold[NSTAGE-1])
                perf_ret_q <= perf_ret_q + 32'd1;
            if (stall_req)
                perf_stl_q <= perf_stl_q + 32'd1;
        end
    end

    assign perf_retired = perf_ret_q;
    assign perf_stall   = perf_stl_q;
`else
    assign perf_retired = '0;
    assign perf_stall   = '0;
`endif
endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Directed table-driven bench for ctrl_pipe_chain (NSTAGE=3) plus multicycle/flush/perf sequences.
module tb_ctrl_pipe_chain;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [15:0] cd;
    logic        vd, md;
    logic [2:0]  st, fl;
    logic [47:0] cq;
    logic [2:0]  vq;
    logic        sreq, busy, done;
    logic [31:0] pret, pstl;

    logic [15:0] cd36;
    logic        vd36, md36;
    logic [2:0]  st36, fl36;
    logic [47:0] cq36;
    logic [2:0]  vq36;
    logic        sreq36, busy36, done36;
    logic [31:0] pret36, pstl36;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ctrl_pipe_chain #(.CTRL_W(16), .NSTAGE(3), .MC_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .ctrl_d(cd), .valid_d(vd), .mc_d(md),
        .stall(st), .flush(fl), .ctrl_q(cq), .valid_q(vq),
        .stall_req(sreq), .mc_busy(busy), .mc_done(done),
        .perf_retired(pret), .perf_stall(pstl)
    );

    ctrl_pipe_chain #(.CTRL_W(16), .NSTAGE(3), .MC_CYCLES(36)) dut36 (
        .clk(clk), .rst(rst), .ctrl_d(cd36), .valid_d(vd36), .mc_d(md36),
        .stall(st36), .flush(fl36), .ctrl_q(cq36), .valid_q(vq36),
        .stall_req(sreq36), .mc_busy(busy36), .mc_done(done36),
        .perf_retired(pret36), .perf_stall(pstl36)
    );

    typedef struct {
        logic [15:0] cd;
        logic        vd, md;
        logic [2:0]  st, fl;
        logic        sreq;
        logic [15:0] e2, e1, e0;
        logic [2:0]  ev;
        logic        eb, edn;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(logic [15:0] c, logic v, logic m, logic [2:0] s, logic [2:0] f,
                                logic sr, logic [15:0] e2, logic [15:0] e1, logic [15:0] e0,
                                logic [2:0] ev, logic eb, logic edn);
        vec_t r;
        r.cd = c; r.vd = v; r.md = m; r.st = s; r.fl = f; r.sreq = sr;
        r.e2 = e2; r.e1 = e1; r.e0 = e0; r.ev = ev; r.eb = eb; r.edn = edn;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        //           cd     vd  md  st      fl      sreq  e2     e1     e0     ev      busy done
        tbl[0]  = mk(16'h01, 1, 0, 3'b000, 3'b000, 0, 16'h00, 16'h00, 16'h01, 3'b001, 0, 0);
        tbl[1]  = mk(16'h02, 1, 0, 3'b000, 3'b000, 0, 16'h00, 16'h01, 16'h02, 3'b011, 0, 0);
        tbl[2]  = mk(16'h03, 1, 0, 3'b000, 3'b000, 0, 16'h01, 16'h02, 16'h03, 3'b111, 0, 0);
        tbl[3]  = mk(16'hAA, 1, 0, 3'b000, 3'b000, 0, 16'h02, 16'h03, 16'hAA, 3'b111, 0, 0);
        tbl[4]  = mk(16'hBB, 1, 0, 3'b001, 3'b000, 1, 16'h03, 16'h00, 16'hAA, 3'b101, 0, 0);
        tbl[5]  = mk(16'hBB, 1, 0, 3'b001, 3'b000, 1, 16'h00, 16'h00, 16'hAA, 3'b001, 0, 0);
        tbl[6]  = mk(16'hBB, 1, 0, 3'b000, 3'b000, 0, 16'h00, 16'hAA, 16'hBB, 3'b011, 0, 0);
        tbl[7]  = mk(16'hCC, 1, 0, 3'b011, 3'b001, 1, 16'h00, 16'hAA, 16'h00, 3'b010, 0, 0);
        tbl[8]  = mk(16'hCC, 1, 0, 3'b000, 3'b000, 0, 16'hAA, 16'h00, 16'hCC, 3'b101, 0, 0);
        tbl[9]  = mk(16'hDD, 1, 0, 3'b100, 3'b100, 1, 16'h00, 16'h00, 16'hCC, 3'b001, 0, 0);
        tbl[10] = mk(16'h0F, 1, 1, 3'b000, 3'b000, 0, 16'h00, 16'hCC, 16'h0F, 3'b011, 1, 0);
        tbl[11] = mk(16'h10, 1, 0, 3'b000, 3'b000, 1, 16'hCC, 16'h00, 16'h0F, 3'b101, 1, 0);
        tbl[12] = mk(16'h10, 1, 0, 3'b000, 3'b000, 1, 16'h00, 16'h00, 16'h0F, 3'b001, 1, 0);
        tbl[13] = mk(16'h10, 1, 0, 3'b000, 3'b000, 1, 16'h00, 16'h00, 16'h0F, 3'b001, 1, 1);
        tbl[14] = mk(16'h10, 1, 0, 3'b000, 3'b000, 0, 16'h00, 16'h0F, 16'h10, 3'b011, 0, 0);
        tbl[15] = mk(16'h11, 1, 0, 3'b000, 3'b000, 0, 16'h0F, 16'h10, 16'h11, 3'b111, 0, 0);
        tbl[16] = mk(16'h20, 1, 1, 3'b000, 3'b000, 0, 16'h10, 16'h11, 16'h20, 3'b111, 1, 0);
        tbl[17] = mk(16'h21, 1, 0, 3'b000, 3'b000, 1, 16'h11, 16'h00, 16'h20, 3'b101, 1, 0);
        tbl[18] = mk(16'h21, 1, 0, 3'b000, 3'b000, 1, 16'h00, 16'h00, 16'h20, 3'b001, 1, 0);
        tbl[19] = mk(16'h21, 1, 0, 3'b000, 3'b000, 1, 16'h00, 16'h00, 16'h20, 3'b001, 1, 1);
        tbl[20] = mk(16'h21, 1, 0, 3'b010, 3'b000, 1, 16'h00, 16'h00, 16'h20, 3'b001, 1, 1);
        tbl[21] = mk(16'h21, 1, 0, 3'b000, 3'b000, 0, 16'h00, 16'h20, 16'h21, 3'b011, 0, 0);
        tbl[22] = mk(16'h00, 0, 0, 3'b000, 3'b000, 0, 16'h20, 16'h21, 16'h00, 3'b110, 0, 0);

        cd = '0; vd = 0; md = 0; st = '0; fl = '0;
        cd36 = '0; vd36 = 0; md36 = 0; st36 = '0; fl36 = '0;

        // Reset state
        #12;
        chk("rst_ctrl", cq, 0);
        chk("rst_valid", vq, 0);
        chk("rst_sreq", sreq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pret", pret, 0);
        chk("rst_pstl", pstl, 0);
        chk("rst_busy36", busy36, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            cd = tbl[i].cd; vd = tbl[i].vd; md = tbl[i].md; st = tbl[i].st; fl = tbl[i].fl;
            #1;
            chk($sformatf("v%0d_sreq", i), sreq, tbl[i].sreq);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ctrl", i), cq, {tbl[i].e2, tbl[i].e1, tbl[i].e0});
            chk($sformatf("v%0d_valid", i), vq, tbl[i].ev);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].eb);
            chk($sformatf("v%0d_done", i), done, tbl[i].edn);
        end

        // MC_CYCLES=36: flush stage 0 during the 10th BUSY cycle.
        @(negedge clk);
        cd36 = 16'h55; vd36 = 1; md36 = 1;
        @(posedge clk);
        #1;
        chk("mc36_busy_c1", busy36, 1);
        chk("mc36_ctrl0", cq36[15:0], 16'h55);
        @(negedge clk);
        cd36 = 16'h77; md36 = 0;
        repeat (9) @(posedge clk);
        #1;
        chk("mc36_busy_c10", busy36, 1);
        chk("mc36_done_c10", done36, 0);
        chk("mc36_sreq_c10", sreq36, 1);
        chk("mc36_held", cq36[15:0], 16'h55);
        @(negedge clk);
        fl36 = 3'b001; vd36 = 0;
        @(posedge clk);
        #1;
        fl36 = 3'b000;
        #1;
        chk("mc36_flush_busy", busy36, 0);
        chk("mc36_flush_done", done36, 0);
        chk("mc36_flush_sreq", sreq36, 0);
        chk("mc36_flush_v0", vq36[0], 0);

        // Perf: 5 ops retire, 3 stall cycles, then async reset mid-cycle.
        @(negedge clk);
        rst = 1'b1; cd = '0; vd = 0; md = 0; st = '0; fl = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            cd = 16'(k); vd = 1;
            @(posedge clk);
        end
        @(negedge clk);
        vd = 0; cd = '0; st = 3'b001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        st = 3'b000;
        repeat (4) @(posedge clk);
        #1;
        chk("perf_valid_drained", vq, 3'b000);
`ifdef CTRL_PIPE_PERF_EN
        chk("perf_retired", pret, 5);
        chk("perf_stall", pstl, 3);
`else
        chk("perf_retired_tied", pret, 0);
        chk("perf_stall_tied", pstl, 0);
`endif
        #2;
        rst = 1'b1;
        #1;
        chk("perf_rst_ret", pret, 0);
        chk("perf_rst_stl", pstl, 0);
        chk("perf_rst_valid", vq, 0);
        #10;
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
